// File: rtl/dimm_bank_model_if.sv
// DDR command/address and DQ bus between the controller and the DIMM model.
interface dimm_bank_model_if #(
  parameter int unsigned BG_W = 2,
  parameter int unsigned BA_W = 2,
  parameter int unsigned DQ_W = 8
);
  logic              cs_n;
  logic              act_n;
  logic              ras_n_a16;
  logic              cas_n_a15;
  logic              we_n_a14;
  logic [BG_W-1:0]   bg_addr;
  logic [BA_W-1:0]   ba_addr;
  logic [13:0]       addr;
  logic [2*DQ_W-1:0] dq_in;
  logic [2*DQ_W-1:0] dq_out;
  logic              dq_oe;

  modport master (
    output cs_n, act_n, ras_n_a16, cas_n_a15, we_n_a14, bg_addr, ba_addr, addr, dq_in,
    input  dq_out, dq_oe
  );

  modport slave (
    input  cs_n, act_n, ras_n_a16, cas_n_a15, we_n_a14, bg_addr, ba_addr, addr, dq_in,
    output dq_out, dq_oe
  );
endinterface

// File: rtl/dimm_bank_model.sv
// Behavioural DDR4 DIMM: command decode, per-bank open-row table, latency-timed
// CAS queue and BL8/BC4 burst engine over a burst-wide memory.
module dimm_bank_model #(
  parameter int unsigned BG_W      = 2,
  parameter int unsigned BA_W      = 2,
  parameter int unsigned ROW_W     = 17,
  parameter int unsigned COL_W     = 10,
  parameter int unsigned DQ_W      = 8,
  parameter int unsigned CAS_DEPTH = 8,
  parameter int unsigned MEM_AW    = 8
) (
  input  logic                    clock_t,
  input  logic                    reset_n,
  dimm_bank_model_if.slave        ddr,
  input  logic                    bl_otf,
  input  logic                    bl8,
  input  logic [4:0]              cl,
  input  logic [4:0]              cwl,
  output logic [4:0]              err,
  output logic [15:0]             rd_count,
  output logic [15:0]             wr_count
);
  localparam int unsigned NB_W   = BG_W + BA_W;
  localparam int unsigned NBANK  = 2 ** NB_W;
  localparam int unsigned PTR_W  = $clog2(CAS_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned PAIR_W = 2 * DQ_W;
  localparam int unsigned WORD_W = 8 * DQ_W;

  typedef enum logic [2:0] {
    CMD_NOP, CMD_ACT, CMD_MRS, CMD_REF, CMD_PRE, CMD_WR, CMD_RD
  } cmd_e;

  typedef enum logic { ST_IDLE, ST_BURST } state_e;

  typedef struct packed {
    logic               rd;
    logic [NB_W-1:0]    bank;
    logic [ROW_W-1:0]   row;
    logic [COL_W-4:0]   col_hi;
    logic               bc4;
    logic               ap;
    logic [15:0]        due;
  } cas_t;

  logic [15:0]        now;
  logic [NBANK-1:0]   bank_open;
  logic [ROW_W-1:0]   row_tab [NBANK];
  cas_t               q [CAS_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   q_cnt;
  logic [WORD_W-1:0]  mem [2**MEM_AW];

  state_e             state;
  logic [1:0]         beat_cnt;
  logic [1:0]         pidx;
  logic               cur_rd;
  logic               cur_ap;
  logic [NB_W-1:0]    cur_bank;
  logic [MEM_AW-1:0]  cur_idx;
  logic [WORD_W-1:0]  word_q;

  cmd_e               cmd_c;
  logic [NB_W-1:0]    bank_c;
  logic [ROW_W-1:0]   row_c;
  logic               cas_c;
  cas_t               entry_c;
  cas_t               head_c;
  logic [15:0]        lag_c;
  logic               start_c;
  logic               push_ok_c;
  logic               last_c;
  logic [1:0]         next_pair_c;
  logic [WORD_W-1:0]  mem_rd_c;
  logic [WORD_W-1:0]  wword_c;
  logic               mem_we_c;

  // Command decode and CAS queue entry construction.
  always_comb begin
    cmd_c  = CMD_NOP;
    bank_c = {ddr.bg_addr, ddr.ba_addr};
    row_c  = ROW_W'({ddr.ras_n_a16, ddr.cas_n_a15, ddr.we_n_a14, ddr.addr});
    if (!ddr.cs_n) begin
      if (!ddr.act_n) begin
        cmd_c = CMD_ACT;
      end else begin
        case ({ddr.ras_n_a16, ddr.cas_n_a15, ddr.we_n_a14})
          3'b000:  cmd_c = CMD_MRS;
          3'b001:  cmd_c = CMD_REF;
          3'b010:  cmd_c = CMD_PRE;
          3'b100:  cmd_c = CMD_WR;
          3'b101:  cmd_c = CMD_RD;
          default: cmd_c = CMD_NOP;
        endcase
      end
    end
    cas_c          = (cmd_c == CMD_WR) || (cmd_c == CMD_RD);
    entry_c.rd     = (cmd_c == CMD_RD);
    entry_c.bank   = bank_c;
    entry_c.row    = row_tab[bank_c];
    entry_c.col_hi = ddr.addr[COL_W-1:3];
    entry_c.bc4    = bl_otf ? ~ddr.addr[12] : ~bl8;
    entry_c.ap     = ddr.addr[10];
    entry_c.due    = now + (entry_c.rd ? 16'(cl) : 16'(cwl));
  end

  // Queue head scheduling, burst sequencing and write-word merge.
  always_comb begin
    head_c      = q[rd_ptr];
    lag_c       = now - head_c.due;
    start_c     = ((state == ST_IDLE) || (beat_cnt == 2'd0)) &&
                  (q_cnt != '0) && !lag_c[15];
    push_ok_c   = cas_c && ((q_cnt != CNT_W'(CAS_DEPTH)) || start_c);
    last_c      = (state == ST_BURST) && (beat_cnt == 2'd1);
    next_pair_c = 2'(pidx + 2'd1);
    mem_rd_c    = mem[MEM_AW'({head_c.bank, head_c.row, head_c.col_hi})];
    wword_c     = word_q;
    wword_c[32'(next_pair_c)*PAIR_W +: PAIR_W] = ddr.dq_in;
    mem_we_c    = last_c && !cur_rd;
  end

  // Memory array has no reset so contents survive reset_n.
  always_ff @(posedge clock_t) begin
    if (mem_we_c) mem[cur_idx] <= wword_c;
  end

  // CAS queue storage.
  always_ff @(posedge clock_t) begin
    if (push_ok_c) q[wr_ptr] <= entry_c;
  end

  // Cycle counter, queue pointers, burst FSM, bank table, errors and counters.
  always_ff @(posedge clock_t or negedge reset_n) begin
    if (!reset_n) begin
      now        <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      q_cnt      <= '0;
      state      <= ST_IDLE;
      beat_cnt   <= '0;
      pidx       <= '0;
      cur_rd     <= 1'b0;
      cur_ap     <= 1'b0;
      cur_bank   <= '0;
      cur_idx    <= '0;
      word_q     <= '0;
      bank_open  <= '0;
      for (int unsigned i = 0; i < NBANK; i++) row_tab[i] <= '0;
      ddr.dq_out <= '0;
      ddr.dq_oe  <= 1'b0;
      err        <= '0;
      rd_count   <= '0;
      wr_count   <= '0;
    end else begin
      now   <= now + 16'd1;
      q_cnt <= q_cnt + CNT_W'(push_ok_c) - CNT_W'(start_c);
      if (push_ok_c) wr_ptr <= PTR_W'(wr_ptr + 1'b1);
      if (start_c)   rd_ptr <= PTR_W'(rd_ptr + 1'b1);
      if (cas_c && !push_ok_c) err[3] <= 1'b1;

      if (start_c) begin
        state    <= ST_BURST;
        beat_cnt <= head_c.bc4 ? 2'd1 : 2'd3;
        pidx     <= 2'd0;
        cur_rd   <= head_c.rd;
        cur_ap   <= head_c.ap;
        cur_bank <= head_c.bank;
        cur_idx  <= MEM_AW'({head_c.bank, head_c.row, head_c.col_hi});
        if (lag_c != 16'd0) err[4] <= 1'b1;
        if (head_c.rd) begin
          word_q     <= mem_rd_c;
          ddr.dq_out <= mem_rd_c[PAIR_W-1:0];
          ddr.dq_oe  <= 1'b1;
        end else begin
          word_q     <= {mem_rd_c[WORD_W-1:PAIR_W], ddr.dq_in};
          ddr.dq_out <= '0;
          ddr.dq_oe  <= 1'b0;
        end
      end else if ((state == ST_BURST) && (beat_cnt != 2'd0)) begin
        beat_cnt <= 2'(beat_cnt - 2'd1);
        pidx     <= next_pair_c;
        if (cur_rd) begin
          ddr.dq_out <= word_q[32'(next_pair_c)*PAIR_W +: PAIR_W];
          ddr.dq_oe  <= 1'b1;
        end else begin
          word_q     <= wword_c;
          ddr.dq_out <= '0;
          ddr.dq_oe  <= 1'b0;
        end
        if (last_c) begin
          if (cur_rd) rd_count <= rd_count + 16'd1;
          else        wr_count <= wr_count + 16'd1;
        end
      end else begin
        state      <= ST_IDLE;
        ddr.dq_out <= '0;
        ddr.dq_oe  <= 1'b0;
      end

      // Auto-precharge first so a same-cycle command to the bank takes effect.
      if (last_c && cur_ap) bank_open[cur_bank] <= 1'b0;
      case (cmd_c)
        CMD_ACT: begin
          if (bank_open[bank_c]) err[0] <= 1'b1;
          bank_open[bank_c] <= 1'b1;
          row_tab[bank_c]   <= row_c;
        end
        CMD_PRE: begin
          if (ddr.addr[10]) bank_open <= '0;
          else              bank_open[bank_c] <= 1'b0;
        end
        CMD_MRS, CMD_REF: if (|bank_open) err[2] <= 1'b1;
        CMD_WR, CMD_RD:   if (!bank_open[bank_c]) err[1] <= 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_dimm_bank_model.sv
// Directed bench for dimm_bank_model: bursts, BC4 merge, errors, overflow, train, reset.
module tb_dimm_bank_model;
  logic        clk;
  logic        reset_n;
  logic        bl_otf;
  logic        bl8;
  logic [4:0]  cl;
  logic [4:0]  cwl;
  logic [4:0]  err;
  logic [15:0] rd_count;
  logic [15:0] wr_count;
  int          checks;
  int          errors;
  int          cnt_oe;
  logic [15:0] pat [4];

  localparam logic [2:0] RCW_WR  = 3'b100;
  localparam logic [2:0] RCW_RD  = 3'b101;
  localparam logic [2:0] RCW_REF = 3'b001;

  dimm_bank_model_if #(.BG_W(2), .BA_W(2), .DQ_W(8)) ddr ();

  dimm_bank_model dut (
    .clock_t  (clk),
    .reset_n  (reset_n),
    .ddr      (ddr),
    .bl_otf   (bl_otf),
    .bl8      (bl8),
    .cl       (cl),
    .cwl      (cwl),
    .err      (err),
    .rd_count (rd_count),
    .wr_count (wr_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic nop();
    ddr.cs_n = 1'b1; ddr.act_n = 1'b1;
    {ddr.ras_n_a16, ddr.cas_n_a15, ddr.we_n_a14} = 3'b111;
    ddr.bg_addr = '0; ddr.ba_addr = '0; ddr.addr = '0;
  endtask

  // Drive one command for the next rising edge, then return to NOP.
  task automatic cmd(input logic actn, input logic [2:0] rcw, input logic [3:0] bank,
                     input logic [13:0] a);
    ddr.cs_n = 1'b0; ddr.act_n = actn;
    {ddr.ras_n_a16, ddr.cas_n_a15, ddr.we_n_a14} = rcw;
    {ddr.bg_addr, ddr.ba_addr} = bank;
    ddr.addr = a;
    @(negedge clk);
    nop();
  endtask

  task automatic wr_burst(input int lat, input int n, input logic [15:0] e0,
                          input logic [15:0] e1, input logic [15:0] e2, input logic [15:0] e3);
    logic [15:0] ex [4];
    ex[0] = e0; ex[1] = e1; ex[2] = e2; ex[3] = e3;
    wait_cyc(lat - 1);
    for (int k = 0; k < n; k++) begin
      ddr.dq_in = ex[k];
      wait_cyc(1);
    end
  endtask

  task automatic rd_check(input string tag, input int lat, input int n, input logic [15:0] e0,
                          input logic [15:0] e1, input logic [15:0] e2, input logic [15:0] e3);
    logic [15:0] ex [4];
    ex[0] = e0; ex[1] = e1; ex[2] = e2; ex[3] = e3;
    wait_cyc(lat - 1);
    chk({tag, "_oe_pre"}, 32'(ddr.dq_oe), 32'd0);
    for (int k = 0; k < n; k++) begin
      wait_cyc(1);
      chk({tag, "_oe"}, 32'(ddr.dq_oe), 32'd1);
      chk({tag, "_dq"}, 32'(ddr.dq_out), 32'(ex[k]));
    end
    wait_cyc(1);
    chk({tag, "_oe_post"}, 32'(ddr.dq_oe), 32'd0);
  endtask

  initial begin
    checks = 0; errors = 0; cnt_oe = 0;
    pat[0] = 16'h0100; pat[1] = 16'h0302; pat[2] = 16'h0504; pat[3] = 16'h0706;
    reset_n = 1'b0; bl_otf = 1'b0; bl8 = 1'b1; cl = 5'd11; cwl = 5'd9;
    nop(); ddr.dq_in = '0;
    wait_cyc(3);
    chk("rst_dq_out", 32'(ddr.dq_out), 32'd0);
    chk("rst_dq_oe",  32'(ddr.dq_oe),  32'd0);
    chk("rst_err",    32'(err),        32'd0);
    chk("rst_rd_cnt", 32'(rd_count),   32'd0);
    chk("rst_wr_cnt", 32'(wr_count),   32'd0);
    reset_n = 1'b1;
    wait_cyc(2);

    // BL8 write then read, bank 5 row 0x123 col 0x08.
    cmd(1'b0, 3'b000, 4'd5, 14'h0123);
    cmd(1'b1, RCW_WR, 4'd5, 14'h0008);
    wr_burst(9, 4, 16'h0100, 16'h0302, 16'h0504, 16'h0706);
    wait_cyc(2);
    cmd(1'b1, RCW_RD, 4'd5, 14'h0008);
    rd_check("bl8_rd", 11, 4, 16'h0100, 16'h0302, 16'h0504, 16'h0706);
    chk("bl8_wr_cnt", 32'(wr_count), 32'd1);
    chk("bl8_rd_cnt", 32'(rd_count), 32'd1);
    chk("bl8_err",    32'(err),      32'd0);

    // BC4 merge over a BL8 word, on-the-fly burst length from A12.
    bl_otf = 1'b1;
    cmd(1'b1, RCW_WR, 4'd5, 14'h1010);
    wr_burst(9, 4, 16'h1111, 16'h1111, 16'h1111, 16'h1111);
    wait_cyc(2);
    cmd(1'b1, RCW_WR, 4'd5, 14'h0010);
    wr_burst(9, 2, 16'h2222, 16'h2222, 16'h0, 16'h0);
    wait_cyc(2);
    cmd(1'b1, RCW_RD, 4'd5, 14'h1010);
    rd_check("bc4_rd", 11, 4, 16'h2222, 16'h2222, 16'h1111, 16'h1111);
    chk("bc4_wr_cnt", 32'(wr_count), 32'd3);
    chk("bc4_rd_cnt", 32'(rd_count), 32'd2);
    chk("bc4_err",    32'(err),      32'd0);
    bl_otf = 1'b0;

    // Four reads four clocks apart form one seamless 16-cycle train.
    cl = 5'd20;
    cmd(1'b1, RCW_RD, 4'd5, 14'h0008); wait_cyc(3);
    cmd(1'b1, RCW_RD, 4'd5, 14'h0008); wait_cyc(3);
    cmd(1'b1, RCW_RD, 4'd5, 14'h0008); wait_cyc(3);
    cmd(1'b1, RCW_RD, 4'd5, 14'h0008);
    wait_cyc(7);
    chk("train_oe_pre", 32'(ddr.dq_oe), 32'd0);
    cnt_oe = 0;
    for (int i = 0; i < 16; i++) begin
      wait_cyc(1);
      if (ddr.dq_oe && (ddr.dq_out == pat[i % 4])) cnt_oe++;
    end
    chk("train_good_beats", 32'(cnt_oe), 32'd16);
    wait_cyc(1);
    chk("train_oe_post", 32'(ddr.dq_oe), 32'd0);
    chk("train_err",     32'(err),       32'd0);
    chk("train_rd_cnt",  32'(rd_count),  32'd6);

    // Nine BC4 reads into an 8-deep queue: one dropped, eight bursts returned.
    bl8 = 1'b0; cl = 5'd31;
    for (int i = 0; i < 9; i++) begin
      cmd(1'b1, RCW_RD, 4'd5, 14'h0008);
      wait_cyc(2);
    end
    chk("ovf_err", 32'(err), 32'b01000);
    cnt_oe = 0;
    for (int i = 0; i < 60; i++) begin
      wait_cyc(1);
      if (ddr.dq_oe) cnt_oe++;
    end
    chk("ovf_oe_cycles", 32'(cnt_oe),   32'd16);
    chk("ovf_rd_cnt",    32'(rd_count), 32'd14);
    bl8 = 1'b1;

    // Long-latency write ahead of a short-latency read forces a late start.
    cwl = 5'd20; cl = 5'd2;
    cmd(1'b1, RCW_WR, 4'd5, 14'h0018);
    cmd(1'b1, RCW_RD, 4'd5, 14'h0008);
    wait_cyc(40);
    chk("late_err",    32'(err),      32'b11000);
    chk("late_wr_cnt", 32'(wr_count), 32'd4);
    chk("late_rd_cnt", 32'(rd_count), 32'd15);

    // Protocol errors after a fresh reset.
    reset_n = 1'b0; wait_cyc(2); reset_n = 1'b1; wait_cyc(1);
    chk("perr_rst_err", 32'(err), 32'd0);
    cl = 5'd5;
    cmd(1'b1, RCW_RD, 4'd0, 14'h0000);
    chk("perr_cas_closed", 32'(err), 32'b00010);
    cmd(1'b0, 3'b000, 4'd0, 14'h0000);
    cmd(1'b0, 3'b000, 4'd0, 14'h0001);
    chk("perr_act_open", 32'(err), 32'b00011);
    cmd(1'b1, RCW_REF, 4'd0, 14'h0000);
    chk("perr_ref_open", 32'(err), 32'b00111);
    wait_cyc(20);
    chk("perr_sticky", 32'(err), 32'b00111);

    // Auto-precharge; memory content survives the resets.
    reset_n = 1'b0; wait_cyc(2); reset_n = 1'b1; wait_cyc(1);
    cmd(1'b0, 3'b000, 4'd5, 14'h0123);
    cmd(1'b1, RCW_RD, 4'd5, 14'h0408);
    rd_check("ap_rd", 5, 4, 16'h0100, 16'h0302, 16'h0504, 16'h0706);
    chk("ap_err_before", 32'(err), 32'd0);
    cmd(1'b1, RCW_RD, 4'd5, 14'h0008);
    chk("ap_bank_closed", 32'(err), 32'b00010);
    wait_cyc(12);

    // Reset asserted mid-read clears outputs immediately.
    cmd(1'b1, RCW_RD, 4'd5, 14'h0008);
    wait_cyc(5);
    chk("mid_oe_active", 32'(ddr.dq_oe), 32'd1);
    wait_cyc(1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_oe",     32'(ddr.dq_oe),  32'd0);
    chk("mid_rst_dq",     32'(ddr.dq_out), 32'd0);
    chk("mid_rst_err",    32'(err),        32'd0);
    chk("mid_rst_rd_cnt", 32'(rd_count),   32'd0);
    chk("mid_rst_wr_cnt", 32'(wr_count),   32'd0);
    wait_cyc(2);
    reset_n = 1'b1;
    cnt_oe = 0;
    for (int i = 0; i < 12; i++) begin
      wait_cyc(1);
      if (ddr.dq_oe) cnt_oe++;
    end
    chk("mid_rst_no_resume", 32'(cnt_oe), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dimm_bank_model.md
# dimm_bank_model

Parametrised, single-clock DIMM behavioural model for the DDR4 bench. It samples the command/address bus every `clock_t`, decodes MRS/REF/PRE/ACT/WR/RD, and tracks the open row of every bank. CAS commands are queued and executed after a programmable CL/CWL latency as BL8 or BC4 bursts, against an internal burst-wide memory. Protocol violations are flagged through sticky error bits. It sits opposite the controller on the DDR interface.

## Interface
- `BG_W`, 2: bank-group address width.
- `BA_W`, 2: bank address width; NBANK = 2^(BG_W+BA_W).
- `ROW_W`, 17: row address width; the row is {ras_n_a16, cas_n_a15, we_n_a14, addr[13:0]}, truncated to ROW_W.
- `COL_W`, 10: column width, addr[COL_W-1:0].
- `DQ_W`, 8: DQ width. One beat pair (rise, fall) is carried per clock.
- `CAS_DEPTH`, 8: CAS queue entries, a power of two.
- `MEM_AW`, 8: memory depth is 2^MEM_AW burst words of 8*DQ_W bits.

Ports:
- `clock_t` in 1: sole clock; every register uses the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `cs_n, act_n, ras_n_a16, cas_n_a15, we_n_a14` in 1 each: command pins.
- `bg_addr` in BG_W; `ba_addr` in BA_W; `addr` in 14: A13..A0, with A12 = BC_n and A10 = AP.
- `bl_otf` in 1: 1 = burst length taken from A12 at CAS time; 0 = fixed by `bl8`.
- `bl8` in 1: fixed-mode burst, 1 = BL8, 0 = BC4.
- `cl`, `cwl` in 5 each: read and write latency in clocks, legal range 2..31.
- `dq_in` in 2*DQ_W: write beat pair, with the earlier beat in the low half.
- `dq_out` out 2*DQ_W: read beat pair.
- `dq_oe` out 1: `dq_out` is valid.
- `err` out 5, sticky: [0] ACT to open bank, [1] CAS to closed bank, [2] REF or MRS with a bank open, [3] CAS queue overflow, [4] late burst start.
- `rd_count`, `wr_count` out 16: completed bursts, wrapping.

## Operation
- **Decode.** Active when cs_n=0.
  - act_n=0 → ACT.
  - Otherwise {ras, cas, we}: 000 MRS, 001 REF, 010 PRE, 100 WR, 101 RD.
  - Anything else, or cs_n=1 → NOP.
- **Bank table.** Each bank holds an open flag and a row.
  - ACT: sets open and stores the row. If the bank is already open, the row is overwritten and err[0] is set.
  - PRE: closes bank {bg, ba}; with A10=1 it closes all banks.
  - REF or MRS with any bank open sets err[2]. The table is unchanged.
- **CAS queue.**
  - RD/WR pushes {rw, bank, row from the table, col, bc4, ap, due}.
  - due = now + (rd ? cl : cwl), where now is a free-running 16-bit cycle counter and due wraps mod 2^16.
  - CAS to a closed bank sets err[1] and is still queued, using the stale row.
  - Push when full is dropped and sets err[3].
  - Simultaneous push and pop is allowed when full.
- **Burst FSM** (IDLE / BURST).
  - IDLE→BURST when the queue is non-empty and (now − head.due) mod 2^16 < 2^15, i.e. due has been reached. The head pops in that cycle.
  - If now ≠ head.due at start, err[4] is set.
  - The beat counter loads 3 for BL8 or 1 for BC4.
  - BURST→IDLE after the count reaches 0, unless the next head is due. In that case the FSM re-enters BURST directly, with no gap.
- **Memory index.** Low MEM_AW bits of {bank, row, col[COL_W-1:3]}.
- **Read burst.**
  - The word is fetched at burst start.
  - Beat pair k (k = 0..3) drives `dq_out` with beats 2k, 2k+1, with `dq_oe`=1.
  - BC4 returns beats 0..3.
  - Unwritten locations return 0.
- **Write burst.**
  - `dq_in` is captured each burst cycle.
  - The word is committed on the final burst cycle edge. BC4 writes beats 0..3 only; beats 4..7 are preserved.
- **Auto-precharge.** AP=1 closes the bank on the final burst cycle.
- **Counters.** `rd_count`/`wr_count` increment on the final burst cycle.
- **Reset.** `reset_n`=0 mid-burst aborts the burst; any pending write is lost, but memory contents are preserved.

## Timing
- Command sampled at edge T.
- Read: `dq_oe`=1 during cycles T+cl .. T+cl+3 (BL8) or T+cl .. T+cl+1 (BC4). `dq_out` is registered.
- Write: `dq_in` is sampled at edges T+cwl .. T+cwl+3 (BL8) or .. T+cwl+1 (BC4). The commit is at the last of those edges.
- A read whose burst starts after the write commit edge returns the new data.
- Back-to-back CAS four clocks apart, with equal latency, produce a seamless burst train.
- ACT at T is visible to a CAS at T+1.
- Reset values:
  - `dq_out`=0, `dq_oe`=0, `err`=0, counters=0.
  - Queue empty, all banks closed, FSM IDLE, now=0.

## Test plan
- **BL8 write/read.** ACT bank 5 row 0x123; WR col 0x08 with cwl=9, driving pairs 0x0100, 0x0302, 0x0504, 0x0706. Then RD col 0x08 with cl=11 → `dq_oe` 4 cycles from T+11 returning the same pairs; wr_count=rd_count=1, err=0.
- **BC4 merge (bl_otf=1).** BL8 write 0x11 × 8, then WR with A12=0 of 0x22 × 4 → subsequent BL8 read returns beats 0–3 = 0x22 and beats 4–7 = 0x11.
- **Protocol errors.** RD to a closed bank → err[1]; ACT twice to bank 0 → err[0]; REF with a bank open → err[2]; err stays set until reset.
- **Overflow.** Nine RDs with cl=31 and CAS_DEPTH=8 → err[3]=1; exactly 8 bursts are returned.
- **Seamless train and late start.** Four RDs four clocks apart → 16 contiguous `dq_oe` cycles, err[4]=0. WR cwl=20 followed by RD cl=2 → the RD starts late, err[4]=1.
- **Reset and auto-precharge.** Assert `reset_n`=0 at beat 2 of a read → `dq_oe`=0 immediately, all outputs at reset values. A RD with AP=1 → a later RD to the same bank without ACT sets err[1].
